// File: rtl/eth_tx_framer.sv
// GMII-side Ethernet TX framer: preamble/SFD, payload, optional zero pad, CRC-32 FCS, IFG.
// Build option: define ETH_TX_PAD_EN to zero-pad short frames up to MIN_FRAME bytes.
module eth_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_en,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_underrun
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
`ifdef ETH_TX_PAD_EN
    PAD,
`endif
    FCS,
    IFG
  } state_t;

`ifdef ETH_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [15:0] PRE_N   = 16'(PREAMBLE_LEN);
  localparam logic [15:0] IFG_N   = 16'(IFG_BYTES);
  localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME);

  state_t      st;
  logic [15:0] ph;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic        corrupt;
  logic        short_frame;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [10:0] sat_inc(input logic [10:0] c);
    return (c == 11'h7FF) ? c : c + 11'd1;
  endfunction

  // bad=1 sends the raw register, i.e. the complement of the true FCS
  function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic bad,
                                          input logic [1:0] idx);
    logic [31:0] w;
    w = bad ? c : ~c;
    w = w >> {idx, 3'b000};
    return w[7:0];
  endfunction

  assign short_frame = PAD_EN && (byte_cnt < MIN_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      ph           <= 16'd0;
      byte_cnt     <= 11'd0;
      crc          <= 32'hFFFF_FFFF;
      corrupt      <= 1'b0;
      o_ready      <= 1'b0;
      o_tx_data    <= 8'h00;
      o_tx_en      <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_underrun   <= 1'b0;
      unique case (st)
        IDLE: begin
          if (i_valid) begin
            st        <= PREAMBLE;
            ph        <= 16'd1;
            crc       <= 32'hFFFF_FFFF;
            byte_cnt  <= 11'd0;
            corrupt   <= 1'b0;
            o_tx_data <= 8'h55;
            o_tx_en   <= 1'b1;
            o_busy    <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (ph == PRE_N) begin
            st        <= SFD;
            o_tx_data <= 8'hD5;
            o_ready   <= 1'b1;
          end else begin
            ph <= ph + 16'd1;
          end
        end
        // o_ready low here means the last byte is already on the line
        SFD, PAYLOAD: begin
          if (o_ready) begin
            if (i_valid) begin
              st        <= PAYLOAD;
              o_tx_data <= i_data;
              crc       <= crc_byte(crc, i_data);
              byte_cnt  <= sat_inc(byte_cnt);
              if (i_last) o_ready <= 1'b0;
            end else begin
              st         <= FCS;
              ph         <= 16'd1;
              corrupt    <= 1'b1;
              o_ready    <= 1'b0;
              o_underrun <= 1'b1;
              o_tx_data  <= fcs_byte(crc, 1'b1, 2'd0);
            end
          end else if (short_frame) begin
`ifdef ETH_TX_PAD_EN
            st        <= PAD;
            o_tx_data <= 8'h00;
            crc       <= crc_byte(crc, 8'h00);
            byte_cnt  <= sat_inc(byte_cnt);
`endif
          end else begin
            st        <= FCS;
            ph        <= 16'd1;
            o_tx_data <= fcs_byte(crc, corrupt, 2'd0);
          end
        end
`ifdef ETH_TX_PAD_EN
        PAD: begin
          if (short_frame) begin
            o_tx_data <= 8'h00;
            crc       <= crc_byte(crc, 8'h00);
            byte_cnt  <= sat_inc(byte_cnt);
          end else begin
            st        <= FCS;
            ph        <= 16'd1;
            o_tx_data <= fcs_byte(crc, corrupt, 2'd0);
          end
        end
`endif
        FCS: begin
          if (ph == 16'd4) begin
            st           <= IFG;
            ph           <= 16'd1;
            o_tx_en      <= 1'b0;
            o_tx_data    <= 8'h00;
            o_frame_done <= 1'b1;
          end else begin
            o_tx_data <= fcs_byte(crc, corrupt, ph[1:0]);
            ph        <= ph + 16'd1;
          end
        end
        IFG: begin
          if (ph == IFG_N) begin
            st     <= IDLE;
            ph     <= 16'd0;
            o_busy <= 1'b0;
          end else begin
            ph <= ph + 16'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: frame contents, FCS, pad, underrun, IFG spacing, async reset.
module tb_eth_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_last;
  logic       o_ready;
  logic [7:0] o_tx_data;
  logic       o_tx_en;
  logic       o_busy;
  logic       o_frame_done;
  logic       o_underrun;

  eth_tx_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_en      (o_tx_en),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_underrun   (o_underrun)
  );

  always #4 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pl [0:127];
  logic [7:0] cap_q [$];
  logic [7:0] exp_q [$];
  int         rise_q [$];
  int         fall_q [$];
  int         cyc = 0, done_cnt = 0, und_cnt = 0, ifg_cyc = 0, ifg_rdy = 0;
  logic       en_d = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (o_tx_en) cap_q.push_back(o_tx_data);
    if (o_frame_done) done_cnt <= done_cnt + 1;
    if (o_underrun) und_cnt <= und_cnt + 1;
    if (o_busy && !o_tx_en) begin
      ifg_cyc <= ifg_cyc + 1;
      if (o_ready) ifg_rdy <= ifg_rdy + 1;
    end
    if (o_tx_en && !en_d) rise_q.push_back(cyc);
    if (!o_tx_en && en_d) fall_q.push_back(cyc - 1);
    en_d <= o_tx_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mcrc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int j = 0; j < 8; j++) begin
      fb = r[0] ^ d[j];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB8_8320;
    end
    return r;
  endfunction

  task automatic build_exp(input int n, input int npad, input bit bad);
    logic [31:0] c, w;
    c = 32'hFFFF_FFFF;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pl[i]);
      c = mcrc(c, pl[i]);
    end
    for (int i = 0; i < npad; i++) begin
      exp_q.push_back(8'h00);
      c = mcrc(c, 8'h00);
    end
    w = bad ? c : ~c;
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[31:24]);
  endtask

  task automatic check_frame(input string tag, input int base);
    logic [7:0] got;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < cap_q.size()) ? cap_q[base + i] : 8'hXX;
      check($sformatf("%s_b%0d", tag, i), 32'(got), 32'(exp_q[i]));
    end
  endtask

  task automatic send(input int n, input int stop_at, input bit hold);
    int i = 0;
    int guard = 0;
    bit xfer;
    i_valid = 1'b1;
    i_data  = pl[0];
    i_last  = (n == 1);
    while (i < n && guard < 1000) begin
      @(negedge clk);
      xfer = o_ready;
      @(posedge clk);
      #1;
      guard++;
      if (xfer) begin
        i++;
        if (i == stop_at) break;
        if (i < n) begin
          i_data = pl[i];
          i_last = (i == n - 1);
        end
      end
    end
    check("send_count", 32'(i), 32'((stop_at > 0) ? stop_at : n));
    i_last = 1'b0;
    if (hold) i_data = 8'hEE;
    else i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (o_busy && guard < 400);
    check("idle_reached", 32'(o_busy), 32'd0);
  endtask

  int base, s_done, s_und, s_ifg, s_rdy, s_rise, s_fall;

  task automatic snap();
    base   = cap_q.size();
    s_done = done_cnt;
    s_und  = und_cnt;
    s_ifg  = ifg_cyc;
    s_rdy  = ifg_rdy;
    s_rise = rise_q.size();
    s_fall = fall_q.size();
  endtask

  initial begin
    int guard;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_en", 32'(o_tx_en), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'h00);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_frame_done), 32'd0);
    check("rst_underrun", 32'(o_underrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready", 32'(o_ready), 32'd0);

    // 60-byte frame, exactly MIN_FRAME
    for (int i = 0; i < 60; i++) pl[i] = 8'(i);
    snap();
    send(60, -1, 1'b0);
    wait_idle();
    build_exp(60, 0, 1'b0);
    check("t1_len", 32'(cap_q.size() - base), 32'd72);
    check_frame("t1", base);
    check("t1_done", 32'(done_cnt - s_done), 32'd1);
    check("t1_underrun", 32'(und_cnt - s_und), 32'd0);
    check("t1_ifg", 32'(ifg_cyc - s_ifg), 32'd12);

    // "123456789"
    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
    snap();
    send(9, -1, 1'b0);
    wait_idle();
`ifdef ETH_TX_PAD_EN
    build_exp(9, 51, 1'b0);
    check("t2_len", 32'(cap_q.size() - base), 32'd72);
    check_frame("t2", base);
`else
    build_exp(9, 0, 1'b0);
    check("t2_len", 32'(cap_q.size() - base), 32'd21);
    check_frame("t2", base);
    check("t2_fcs0", 32'(cap_q[base + 17]), 32'h26);
    check("t2_fcs1", 32'(cap_q[base + 18]), 32'h39);
    check("t2_fcs2", 32'(cap_q[base + 19]), 32'hF4);
    check("t2_fcs3", 32'(cap_q[base + 20]), 32'hCB);
`endif
    check("t2_done", 32'(done_cnt - s_done), 32'd1);

    // underrun after 20 of 64 bytes
    for (int i = 0; i < 64; i++) pl[i] = 8'(i * 3 + 1);
    snap();
    send(64, 20, 1'b0);
    wait_idle();
    build_exp(20, 0, 1'b1);
    check("t3_len", 32'(cap_q.size() - base), 32'd32);
    check_frame("t3", base);
    check("t3_underrun", 32'(und_cnt - s_und), 32'd1);
    check("t3_ifg", 32'(ifg_cyc - s_ifg), 32'd12);

    // back-to-back with i_valid held high
    for (int i = 0; i < 60; i++) pl[i] = 8'hF0 ^ 8'(i);
    snap();
    send(60, -1, 1'b1);
    send(60, -1, 1'b0);
    wait_idle();
    build_exp(60, 0, 1'b0);
    check("t4_len", 32'(cap_q.size() - base), 32'd144);
    check_frame("t4a", base);
    check_frame("t4b", base + 72);
    check("t4_gap", 32'(rise_q[s_rise + 1] - fall_q[s_fall] - 1), 32'd13);
    check("t4_ifg_ready", 32'(ifg_rdy - s_rdy), 32'd0);
    check("t4_done", 32'(done_cnt - s_done), 32'd2);

    // async reset during payload byte 10
    snap();
    i_valid = 1'b1;
    i_data  = 8'h11;
    i_last  = 1'b0;
    guard   = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (cap_q.size() - base < 19 && guard < 300);
    check("t5_reach", 32'(cap_q.size() - base), 32'd19);
    rst_n = 1'b0;
    #1;
    check("t5_tx_en", 32'(o_tx_en), 32'd0);
    check("t5_busy", 32'(o_busy), 32'd0);
    check("t5_ready", 32'(o_ready), 32'd0);
    check("t5_tx_data", 32'(o_tx_data), 32'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base  = cap_q.size();
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (cap_q.size() - base < 9 && guard < 100);
    check("t5_restart", 32'(cap_q.size() - base), 32'd9);
    for (int i = 0; i < 7; i++)
      check($sformatf("t5_pre%0d", i), 32'(cap_q[base + i]), 32'h55);
    check("t5_sfd", 32'(cap_q[base + 7]), 32'hD5);
    check("t5_first", 32'(cap_q[base + 8]), 32'h11);
    i_valid = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
